// File: rtl/dr_capture_ctrl.sv
// Clocked four-phase receiver for an N-bit dual-rail bus: synchronises the rails, detects NULL,
// completion and illegal codes, captures into a valid/ready register. Optional watchdog: DRC_TIMEOUT_EN.
module dr_capture_ctrl #(
  parameter int N           = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] dr_in,
  output logic           ack_out,
  output logic [N-1:0]   dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           err_illegal,
  output logic           timeout,
  input  logic           err_clr
);

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("dr_capture_ctrl: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ACK   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  logic [2*N-1:0] sync_q [SYNC_STAGES];
  logic [2*N-1:0] bus;
  logic [N-1:0]   pair_comp;
  logic [N-1:0]   pair_null;
  logic [N-1:0]   pair_ill;
  logic [N-1:0]   word;
  logic           bus_comp;
  logic           bus_null;
  logic           bus_ill;

  state_e         state_q;
  state_e         state_d;
  logic           ack_q;
  logic [N-1:0]   dout_q;
  logic           dout_valid_q;
  logic           err_illegal_q;
  logic           consume;
  logic           slot_free;
  logic           capture;

  // Each rail passes through its own flop chain; pairs may resolve on different cycles,
  // which the completion detector tolerates because it waits for every pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= dr_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bus = sync_q[SYNC_STAGES-1];

  always_comb begin
    pair_comp = '0;
    pair_null = '0;
    pair_ill  = '0;
    word      = '0;
    for (int i = 0; i < N; i++) begin
      pair_comp[i] = bus[2*i+1] ^ bus[2*i];
      pair_null[i] = ~(bus[2*i+1] | bus[2*i]);
      pair_ill[i]  = bus[2*i+1] & bus[2*i];
      word[i]      = bus[2*i+1];
    end
  end

  assign bus_ill  = |pair_ill;
  assign bus_comp = (&pair_comp) & ~bus_ill;
  assign bus_null = &pair_null;

  assign consume   = dout_valid_q & dout_ready;
  assign slot_free = ~dout_valid_q | dout_ready;
  assign capture   = (state_q == S_WAIT) & ~bus_ill & bus_comp & slot_free;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (bus_ill) begin
          state_d = S_DRAIN;
        end else if (bus_comp && slot_free) begin
          state_d = S_ACK;
        end
      end
      S_ACK, S_DRAIN: begin
        if (bus_null) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Acknowledge is high in every state except S_WAIT, so it follows the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT;
      ack_q         <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_q         <= (state_d != S_WAIT);
      if (capture) begin
        dout_q       <= word;
        dout_valid_q <= 1'b1;
      end else if (consume) begin
        dout_valid_q <= 1'b0;
      end
      err_illegal_q <= (err_illegal_q & ~err_clr) | bus_ill;
    end
  end

  assign ack_out     = ack_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign err_illegal = err_illegal_q;

`ifdef DRC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          timeout_q;

  // Idle (null in S_WAIT) and every phase change restart the watchdog.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || ((state_q == S_WAIT) && bus_null)) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= (timeout_q & ~err_clr) | (cnt_d == CW'(TIMEOUT));
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dr_capture_ctrl.sv
// Directed bench for dr_capture_ctrl (N=10, SYNC_STAGES=2, TIMEOUT=8).
module tb_dr_capture_ctrl;

  localparam int N = 10;

  logic          clk;
  logic          rst_n;
  logic [2*N-1:0] dr_in;
  logic          ack_out;
  logic [N-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          err_illegal;
  logic          timeout;
  logic          err_clr;

  int tests = 0;
  int fails = 0;

  dr_capture_ctrl #(.N(N), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dr_in      (dr_in),
    .ack_out    (ack_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err_illegal(err_illegal),
    .timeout    (timeout),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] enc(input logic [N-1:0] w);
    logic [2*N-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack_out); end
    tests++; if (dout !== 10'h000) begin fails++; $display("FAIL reset_dout got %h want 000", dout); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    tests++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_illegal); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    dr_in = enc(10'h2A5);
    tick(); tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL basic_ack_early got %b want 0", ack_out); end
    tick();
    tests++; if (ack_out !== 1'b1) begin fails++; $display("FAIL basic_ack got %b want 1", ack_out); end
    tests++; if (dout !== 10'h2A5) begin fails++; $display("FAIL basic_dout got %h want 2a5", dout); end
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", dout_valid); end
    dr_in = '0;
    tick(); tick();
    tests++; if (ack_out !== 1'b1) begin fails++; $display("FAIL basic_ack_hold got %b want 1", ack_out); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL basic_consumed got %b want 0", dout_valid); end
    tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL basic_ack_null got %b want 0", ack_out); end
  endtask

  task automatic test_backpressure();
    dout_ready = 1'b0;
    dr_in = enc(10'h155);
    repeat (3) tick();
    tests++; if (dout !== 10'h155 || ack_out !== 1'b1) begin fails++; $display("FAIL bp_first got dout=%h ack=%b want 155/1", dout, ack_out); end
    dr_in = '0;
    repeat (3) tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL bp_null got %b want 0", ack_out); end
    dr_in = enc(10'h0AA);
    repeat (5) tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL bp_ack_held got %b want 0", ack_out); end
    tests++; if (dout !== 10'h155 || dout_valid !== 1'b1) begin fails++; $display("FAIL bp_stable got dout=%h v=%b want 155/1", dout, dout_valid); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    tests++; if (dout !== 10'h0AA || dout_valid !== 1'b1 || ack_out !== 1'b1) begin fails++; $display("FAIL bp_reload got dout=%h v=%b ack=%b want 0aa/1/1", dout, dout_valid, ack_out); end
    dr_in = '0;
    repeat (3) tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL bp_null2 got %b want 0", ack_out); end
    dout_ready = 1'b1;
    tick();
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", dout_valid); end
  endtask

  task automatic test_partial();
    logic [N-1:0] w;
    int bad;
    w = 10'h2A5;
    bad = 0;
    for (int k = 0; k < N; k++) begin
      dr_in[2*k +: 2] = w[k] ? 2'b10 : 2'b01;
      tick();
      if (ack_out !== 1'b0) bad++;
    end
    tick();
    if (ack_out !== 1'b0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL partial_early_ack got %0d early highs want 0", bad); end
    tick();
    tests++; if (ack_out !== 1'b1 || dout !== 10'h2A5) begin fails++; $display("FAIL partial_capture got ack=%b dout=%h want 1/2a5", ack_out, dout); end
    bad = 0;
    for (int k = 0; k < N; k++) begin
      dr_in[2*k +: 2] = 2'b00;
      tick();
      if (ack_out !== 1'b1) bad++;
    end
    tick();
    if (ack_out !== 1'b1) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL partial_early_release got %0d lows want 0", bad); end
    tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL partial_release got %b want 0", ack_out); end
  endtask

  task automatic test_illegal();
    logic [2*N-1:0] b;
    dout_ready = 1'b0;
    b = enc(10'h000);
    b[7:6] = 2'b11;
    dr_in = b;
    repeat (3) tick();
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL ill_flag got %b want 1", err_illegal); end
    tests++; if (dout_valid !== 1'b0 || ack_out !== 1'b1) begin fails++; $display("FAIL ill_drain got v=%b ack=%b want 0/1", dout_valid, ack_out); end
    dr_in = '0;
    repeat (3) tick();
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL ill_null got %b want 0", ack_out); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL ill_clear got %b want 0", err_illegal); end
    dr_in = b;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL ill_set_wins got %b want 1", err_illegal); end
    dr_in = '0;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (err_illegal !== 1'b0 || ack_out !== 1'b0) begin fails++; $display("FAIL ill_end got err=%b ack=%b want 0/0", err_illegal, ack_out); end
  endtask

  task automatic test_async_reset();
    dout_ready = 1'b0;
    dr_in = enc(10'h0F0);
    repeat (3) tick();
    tests++; if (ack_out !== 1'b1 || dout_valid !== 1'b1) begin fails++; $display("FAIL rst_pre got ack=%b v=%b want 1/1", ack_out, dout_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (ack_out !== 1'b0 || dout_valid !== 1'b0 || dout !== 10'h000) begin fails++; $display("FAIL rst_async got ack=%b v=%b dout=%h want 0/0/000", ack_out, dout_valid, dout); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    tests++; if (ack_out !== 1'b1 || dout !== 10'h0F0) begin fails++; $display("FAIL rst_recapture got ack=%b dout=%h want 1/0f0", ack_out, dout); end
    dr_in = '0;
    dout_ready = 1'b1;
    repeat (3) tick();
    tests++; if (ack_out !== 1'b0 || dout_valid !== 1'b0) begin fails++; $display("FAIL rst_end got ack=%b v=%b want 0/0", ack_out, dout_valid); end
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef DRC_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    dr_in = '0;
    dr_in[9:0] = enc(10'h015) & 20'h003FF;
    repeat (12) tick();
    tests++; if (timeout !== exp_to) begin fails++; $display("FAIL timeout_flag got %b want %b", timeout, exp_to); end
    tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL timeout_no_ack got %b want 0", ack_out); end
    dr_in = '0;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear got %b want 0", timeout); end
  endtask

  initial begin
    rst_n      = 1'b0;
    dr_in      = '0;
    dout_ready = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_partial();
    test_illegal();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
